// File: rtl/pulse_stretcher_if.sv
// Event strobe in, stretched indication out, for pulse_stretcher.
// The master drives pulse_i and retrig_en_i. The slave drives led_o, busy_o and drop_o.
interface pulse_stretcher_if;
    logic pulse_i;
    logic retrig_en_i;
    logic led_o;
    logic busy_o;
    logic drop_o;

    modport master (
        output pulse_i,
        output retrig_en_i,
        input  led_o,
        input  busy_o,
        input  drop_o
    );

    modport slave (
        input  pulse_i,
        input  retrig_en_i,
        output led_o,
        output busy_o,
        output drop_o
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event strobes into a visible LED pulse.
// A forced gap follows each hold, and one extra event can be queued.
//
// state | meaning
// IDLE  | waiting for pulse_i, led off
// HOLD  | led on for HOLD_CYCLES, restartable when retrigger is enabled
// GAP   | led forced off for GAP_CYCLES, events may queue
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 1500000,
    parameter int GAP_CYCLES  = 500000,
    parameter int CNT_W       = 21
) (
    input logic               clk_50MHz_i,
    input logic               rst_async_la_i,
    pulse_stretcher_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             pend_q, pend_n;
    logic             drop_q, drop_n;

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            pend_q  <= pend_n;
            drop_q  <= drop_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        pend_n  = pend_q;
        drop_n  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                if (bus.pulse_i) begin
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A retrigger wins even on the terminal-count cycle.
                if (bus.pulse_i && bus.retrig_en_i) begin
                    cnt_n = '0;
                end else begin
                    if (bus.pulse_i) begin
                        drop_n = pend_q;
                        pend_n = 1'b1;
                    end
                    if (cnt_q == HOLD_TC) begin
                        state_n = ST_GAP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (bus.pulse_i) begin
                    drop_n = pend_q;
                    pend_n = 1'b1;
                end
                if (cnt_q == GAP_TC) begin
                    cnt_n = '0;
                    if (pend_q || bus.pulse_i) begin
                        state_n = ST_HOLD;
                        pend_n  = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                pend_n  = 1'b0;
            end
        endcase
    end

    assign bus.led_o  = (state_q == ST_HOLD);
    assign bus.busy_o = (state_q != ST_IDLE);
    assign bus.drop_o = drop_q;

endmodule
